// File: rtl/dioptase_io_pkg.sv
// dioptase_io_pkg
//   Shared constants and types for the memory-mapped I/O blocks.
//   - RX status word layout: {overflow, 6'b0, count[8:0]}
//   - RX data word layout:   {7'b0, valid, byte[7:0]}
//   - Default sizing of the UART receive buffer
//   - Position of the UART RX interrupt in the 16-bit interrupts vector
package dioptase_io_pkg;

  // RX status register bit positions
  localparam int OVF_BIT   = 15;
  localparam int COUNT_MSB = 8;

  // RX data register: bit that flags a real byte (0 means the pop hit an empty FIFO)
  localparam int VALID_BIT = 8;

  // Default UART RX buffer sizing
  localparam int RX_DEPTH_DEFAULT      = 16;
  localparam int RX_THRESH_DEFAULT     = 8;
  localparam int RX_IDLE_TICKS_DEFAULT = 1000;

  // Bit of the interrupts vector driven by the UART RX buffer irq
  localparam int UART_RX_IRQ_IDX = 2;

  // Idle-timeout tracker: ARMED is counting or waiting for data,
  // FIRED means the timeout for the current idle period was already signalled.
  typedef enum logic {
    TMR_ARMED = 1'b0,
    TMR_FIRED = 1'b1
  } rx_timer_state_e;

endpackage

// File: rtl/uart_rx_buffer_byte_fifo.sv
// byte_fifo
//   Byte-wide circular FIFO with a registered read port.
//   Ports:
//     clk, rst    - clock, asynchronous active-high reset (pointers and count only)
//     push, din   - write strobe and byte; ignored when full unless popping the same cycle
//     pop         - read strobe; ignored when empty
//     dout        - head byte captured on an accepted pop (valid the cycle after)
//     count       - fill level, 0..DEPTH (9 bits so that 256 fits)
//     full, empty - decoded from count
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic [8:0] count,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [7:0]    dout_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]    count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 9'd0);
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    do_push  = push && ((count_q != DEPTH_C) || do_pop);
    // DEPTH is a power of two, so the natural AW-bit wrap is the modulo.
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + 9'(do_push) - 9'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  // When full, wr_ptr == rd_ptr; a push+pop then reads the old head (read-first).
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
    if (do_pop)  dout_q <= mem[rd_ptr_q];
  end

  assign dout  = dout_q;
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == 9'd0);

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   Receive-side buffer between the UART receiver and the memory-mapped I/O region.
//   Ports:
//     clk, rst          - clock, asynchronous active-high reset
//     in_valid, in_data - one-cycle strobe and byte from the UART receiver
//     pop_en            - CPU read of the RX data register
//     rd_data           - {7'b0, valid, byte}, updated one cycle after pop_en
//     status            - {overflow, 6'b0, count[8:0]}
//     clr_ovf           - clears the sticky overflow flag
//     irq               - one-cycle pulse: fill level rose to THRESH, or idle timeout
module uart_rx_buffer
  import dioptase_io_pkg::*;
#(
  parameter int DEPTH      = RX_DEPTH_DEFAULT,
  parameter int THRESH     = RX_THRESH_DEFAULT,
  parameter int IDLE_TICKS = RX_IDLE_TICKS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        pop_en,
  output logic [15:0] rd_data,
  output logic [15:0] status,
  input  logic        clr_ovf,
  output logic        irq
);

  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TICKS);
  localparam logic [8:0]    THRESH_C = 9'(THRESH);

  logic [7:0] fifo_dout;
  logic [8:0] fifo_count;
  logic       fifo_full, fifo_empty;

  logic       push_ok, pop_ok, ovf_set, idle_clear, thresh_hit, timeout_hit;
  logic [8:0] count_next;

  logic            ovf_q, ovf_d;
  logic            rd_valid_q, rd_valid_d;
  logic            irq_q, irq_d;
  logic [IW-1:0]   idle_q, idle_d;
  rx_timer_state_e tmr_state_q, tmr_state_d;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .din   (in_data),
    .pop   (pop_ok),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    pop_ok     = pop_en && !fifo_empty;
    push_ok    = in_valid && (!fifo_full || pop_ok);
    ovf_set    = in_valid && fifo_full && !pop_en;
    count_next = fifo_count + 9'(push_ok) - 9'(pop_ok);

    // Set beats a same-cycle clear so an overflow is never lost.
    ovf_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    // rd_data only changes on a pop request; an empty pop reads back as all-zero.
    rd_valid_d = pop_en ? pop_ok : rd_valid_q;

    // Only an arrival from below counts: draining through THRESH, or
    // bouncing 9->8->9, must not re-interrupt the CPU.
    thresh_hit = push_ok && !pop_ok && (count_next == THRESH_C) && (fifo_count != THRESH_C);

    idle_clear = push_ok || fifo_empty;
    if (idle_clear)
      idle_d = '0;
    else if (idle_q == IDLE_MAX)
      idle_d = idle_q;
    else
      idle_d = idle_q + IW'(1);

    timeout_hit = (tmr_state_q == TMR_ARMED) && !idle_clear &&
                  (idle_d == IDLE_MAX) && (idle_q != IDLE_MAX);

    tmr_state_d = tmr_state_q;
    case (tmr_state_q)
      TMR_ARMED: if (timeout_hit) tmr_state_d = TMR_FIRED;
      TMR_FIRED: if (idle_clear)  tmr_state_d = TMR_ARMED;
      default:   tmr_state_d = TMR_ARMED;
    endcase

    irq_d = thresh_hit || timeout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      irq_q       <= 1'b0;
      idle_q      <= '0;
      tmr_state_q <= TMR_ARMED;
    end else begin
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      irq_q       <= irq_d;
      idle_q      <= idle_d;
      tmr_state_q <= tmr_state_d;
    end
  end

  // The FIFO read register has no reset; the registered valid bit masks it.
  always_comb begin
    rd_data            = '0;
    rd_data[VALID_BIT] = rd_valid_q;
    rd_data[7:0]       = rd_valid_q ? fifo_dout : 8'h00;
    status                = '0;
    status[OVF_BIT]       = ovf_q;
    status[COUNT_MSB:0]   = fifo_count;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;
  localparam int IDLE   = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        pop_en;
  logic [15:0] rd_data;
  logic [15:0] status;
  logic        clr_ovf;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_buffer #(
    .DEPTH      (DEPTH),
    .THRESH     (THRESH),
    .IDLE_TICKS (IDLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .pop_en   (pop_en),
    .rd_data  (rd_data),
    .status   (status),
    .clr_ovf  (clr_ovf),
    .irq      (irq)
  );

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    pop_en = 1'b1;
    cyc();
    pop_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; pop_en = 1'b0; clr_ovf = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    $display("reset  rd_data=%h status=%h irq=%b", rd_data, status, irq);
    total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd got=%h want=0000", rd_data); end
    total++; if (status !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h want=0000", status); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
  endtask

  task automatic test_basic();
    push(8'h41);
    cyc();
    pop();
    $display("basic  pop rd_data=%h status=%h", rd_data, status);
    total++; if (rd_data !== 16'h0141) begin bad++; $display("FAIL basic_rd got=%h want=0141", rd_data); end
    total++; if (status !== 16'h0000) begin bad++; $display("FAIL basic_status got=%h want=0000", status); end
    cyc();
    total++; if (rd_data !== 16'h0141) begin bad++; $display("FAIL basic_hold got=%h want=0141", rd_data); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    total++; if (status !== 16'h0010) begin bad++; $display("FAIL ovf_fill got=%h want=0010", status); end
    push(8'hAA);
    $display("ovf    dropped push status=%h", status);
    total++; if (status !== 16'h8010) begin bad++; $display("FAIL ovf_set got=%h want=8010", status); end
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      $display("ovf    pop %0d rd_data=%h", i, rd_data);
      total++;
      if (rd_data !== {8'h01, 8'(i)}) begin
        bad++; $display("FAIL ovf_pop%0d got=%h want=%h", i, rd_data, {8'h01, 8'(i)});
      end
    end
    total++; if (status !== 16'h8000) begin bad++; $display("FAIL ovf_sticky got=%h want=8000", status); end
    pop();
    total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL ovf_extra_pop got=%h want=0000", rd_data); end
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    $display("ovf    clr status=%h", status);
    total++; if (status !== 16'h0000) begin bad++; $display("FAIL ovf_clr got=%h want=0000", status); end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < THRESH; i++) begin
      push(8'(8'h20 + i));
      $display("thr    push %0d irq=%b status=%h", i, irq, status);
      total++;
      if (irq !== (i == THRESH - 1)) begin
        bad++; $display("FAIL thr_push%0d got=%b want=%b", i, irq, (i == THRESH - 1));
      end
    end
    cyc();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_single got=%b want=0", irq); end
    push(8'h28);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_to9 got=%b want=0", irq); end
    pop();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_to8 got=%b want=0", irq); end
    total++; if (rd_data !== 16'h0120) begin bad++; $display("FAIL thr_head got=%h want=0120", rd_data); end
    push(8'h29);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_back9 got=%b want=0", irq); end
    total++; if (status !== 16'h0009) begin bad++; $display("FAIL thr_count got=%h want=0009", status); end
    for (int i = 0; i < 9; i++) pop();
    cyc();
    total++; if (status !== 16'h0000) begin bad++; $display("FAIL thr_drain got=%h want=0000", status); end
  endtask

  task automatic test_timeout();
    int pulses;
    int first;
    push(8'h61);
    pulses = 0; first = -1;
    for (int k = 1; k <= 3 * IDLE; k++) begin
      cyc();
      if (irq === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    $display("tmo    first window pulses=%0d at=%0d", pulses, first);
    total++; if (pulses !== 1) begin bad++; $display("FAIL tmo_pulses got=%0d want=1", pulses); end
    total++; if (first !== IDLE) begin bad++; $display("FAIL tmo_delay got=%0d want=%0d", first, IDLE); end
    push(8'h62);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL tmo_push_irq got=%b want=0", irq); end
    pulses = 0; first = -1;
    for (int k = 1; k <= IDLE + 4; k++) begin
      cyc();
      if (irq === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    $display("tmo    second window pulses=%0d at=%0d", pulses, first);
    total++; if (pulses !== 1) begin bad++; $display("FAIL tmo_pulses2 got=%0d want=1", pulses); end
    total++; if (first !== IDLE) begin bad++; $display("FAIL tmo_delay2 got=%0d want=%0d", first, IDLE); end
    pop();
    pop();
    total++; if (rd_data !== 16'h0162) begin bad++; $display("FAIL tmo_last got=%h want=0162", rd_data); end
    total++; if (status !== 16'h0000) begin bad++; $display("FAIL tmo_drain got=%h want=0000", status); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    in_valid = 1'b1; in_data = 8'h55; pop_en = 1'b1;
    cyc();
    in_valid = 1'b0; pop_en = 1'b0;
    $display("full   push+pop rd_data=%h status=%h", rd_data, status);
    total++; if (status !== 16'h0010) begin bad++; $display("FAIL full_status got=%h want=0010", status); end
    total++; if (rd_data !== 16'h0110) begin bad++; $display("FAIL full_head got=%h want=0110", rd_data); end
    for (int i = 1; i < DEPTH; i++) begin
      pop();
      total++;
      if (rd_data !== {8'h01, 8'(8'h10 + i)}) begin
        bad++; $display("FAIL full_pop%0d got=%h want=%h", i, rd_data, {8'h01, 8'(8'h10 + i)});
      end
    end
    pop();
    $display("full   last pop rd_data=%h status=%h", rd_data, status);
    total++; if (rd_data !== 16'h0155) begin bad++; $display("FAIL full_last got=%h want=0155", rd_data); end
    total++; if (status !== 16'h0000) begin bad++; $display("FAIL full_drain got=%h want=0000", status); end
  endtask

  task automatic test_empty_and_reset();
    pop();
    $display("empty  pop rd_data=%h", rd_data);
    total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL empty_pop got=%h want=0000", rd_data); end
    in_valid = 1'b1; in_data = 8'h71; pop_en = 1'b1;
    cyc();
    in_valid = 1'b0; pop_en = 1'b0;
    total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL empty_pp_rd got=%h want=0000", rd_data); end
    total++; if (status !== 16'h0001) begin bad++; $display("FAIL empty_pp_cnt got=%h want=0001", status); end
    push(8'h72);
    push(8'h73);
    pop();
    total++; if (rd_data !== 16'h0171) begin bad++; $display("FAIL midrst_pop got=%h want=0171", rd_data); end
    total++; if (status !== 16'h0002) begin bad++; $display("FAIL midrst_cnt got=%h want=0002", status); end
    #2 rst = 1'b1;
    #1;
    $display("rst    async rd_data=%h status=%h irq=%b", rd_data, status, irq);
    total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL arst_rd got=%h want=0000", rd_data); end
    total++; if (status !== 16'h0000) begin bad++; $display("FAIL arst_status got=%h want=0000", status); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b want=0", irq); end
    cyc();
    rst = 1'b0;
    cyc();
    pop();
    $display("rst    post pop rd_data=%h status=%h", rd_data, status);
    total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL arst_pop got=%h want=0000", rd_data); end
    total++; if (status !== 16'h0000) begin bad++; $display("FAIL arst_cnt got=%h want=0000", status); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_threshold();
    test_timeout();
    test_full_simul();
    test_empty_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
